// File: rtl/mimosa_mood_fsm.sv
// Mood core of the moody mimosa: touch edge detect, fold/reopen timing,
// exhaustion after repeated folds and revival from the reanimator.
module mimosa_mood_fsm #(
  parameter int IRRITATE_LIMIT  = 3,
  parameter int EXHAUST_LIMIT   = 4,
  parameter int RECOVERY_CYCLES = 8,
  parameter int COUNTER_WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stimulus,
  input  logic                     reanimated,
  output logic [1:0]               state,
  output logic                     exhausted,
  output logic [COUNTER_WIDTH-1:0] fold_count
);

  typedef enum logic [1:0] {
    OPEN      = 2'b00,
    REOPENING = 2'b01,
    CLOSED    = 2'b10,
    EXHAUSTED = 2'b11
  } mood_t;

  localparam logic [COUNTER_WIDTH-1:0] IRR_LAST  =
    COUNTER_WIDTH'(IRRITATE_LIMIT - 1);
  localparam logic [COUNTER_WIDTH-1:0] FOLD_LAST =
    COUNTER_WIDTH'(EXHAUST_LIMIT - 1);
  localparam logic [COUNTER_WIDTH-1:0] FOLD_MAX  =
    COUNTER_WIDTH'(EXHAUST_LIMIT);
  localparam logic [COUNTER_WIDTH-1:0] T_LAST    =
    COUNTER_WIDTH'(RECOVERY_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] ZERO      = '0;
  localparam logic [COUNTER_WIDTH-1:0] ONE       =
    COUNTER_WIDTH'(1);

  mood_t                    cur_q, cur_n;
  logic [COUNTER_WIDTH-1:0] irr_q, irr_n;
  logic [COUNTER_WIDTH-1:0] tmr_q, tmr_n;
  logic [COUNTER_WIDTH-1:0] fold_q, fold_n;
  logic                     stim_prev;
  logic                     touch;
  logic                     do_fold;
  logic                     expired;

  // Edge history keeps tracking through reset so a held level never counts.
  always_ff @(posedge clk) begin
    stim_prev <= stimulus;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q  <= OPEN;
      irr_q  <= ZERO;
      tmr_q  <= ZERO;
      fold_q <= ZERO;
    end else begin
      cur_q  <= cur_n;
      irr_q  <= irr_n;
      tmr_q  <= tmr_n;
      fold_q <= fold_n;
    end
  end

  assign touch   = stimulus & ~stim_prev;
  assign expired = (tmr_q == T_LAST);

  always_comb begin
    cur_n   = cur_q;
    irr_n   = irr_q;
    tmr_n   = tmr_q;
    fold_n  = fold_q;
    do_fold = 1'b0;
    unique case (cur_q)
      OPEN: begin
        if (touch) begin
          if (irr_q == IRR_LAST) begin
            do_fold = 1'b1;
          end else begin
            irr_n = irr_q + ONE;
            tmr_n = ZERO;
          end
        end else if (expired) begin
          irr_n  = ZERO;
          fold_n = ZERO;
          tmr_n  = ZERO;
        end else begin
          tmr_n = tmr_q + ONE;
        end
      end
      CLOSED: begin
        if (touch) begin
          tmr_n = ZERO;
        end else if (expired) begin
          cur_n = REOPENING;
          tmr_n = ZERO;
        end else begin
          tmr_n = tmr_q + ONE;
        end
      end
      REOPENING: begin
        if (touch) begin
          do_fold = 1'b1;
        end else if (expired) begin
          cur_n = OPEN;
          tmr_n = ZERO;
        end else begin
          tmr_n = tmr_q + ONE;
        end
      end
      EXHAUSTED: begin
        tmr_n = ZERO;
        if (reanimated) begin
          cur_n  = OPEN;
          irr_n  = ZERO;
          fold_n = ZERO;
        end
      end
      default: cur_n = OPEN;
    endcase
    // Shared fold action for OPEN and REOPENING.
    if (do_fold) begin
      irr_n = ZERO;
      tmr_n = ZERO;
      if (fold_q == FOLD_LAST) begin
        cur_n  = EXHAUSTED;
        fold_n = FOLD_MAX;
      end else begin
        cur_n  = CLOSED;
        fold_n = fold_q + ONE;
      end
    end
  end

  assign state      = cur_q;
  assign exhausted  = (cur_q == EXHAUSTED);
  assign fold_count = fold_q;

endmodule

// File: tb/tb_mimosa_mood_fsm.sv
// Directed bench for mimosa_mood_fsm: expectations queued at drive time,
// popped and asserted one cycle later.
module tb_mimosa_mood_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       stimulus;
  logic       reanimated;
  logic [1:0] state;
  logic       exhausted;
  logic [3:0] fold_count;

  int checks = 0;
  int fails  = 0;
  logic [6:0] exp_q[$];

  localparam logic [1:0] S_OPEN = 2'b00;
  localparam logic [1:0] S_REOP = 2'b01;
  localparam logic [1:0] S_CLSD = 2'b10;
  localparam logic [1:0] S_EXH  = 2'b11;

  always #5 clk = ~clk;

  mimosa_mood_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .stimulus   (stimulus),
    .reanimated (reanimated),
    .state      (state),
    .exhausted  (exhausted),
    .fold_count (fold_count)
  );

  task automatic step(input string tag, input logic s,
                      input logic r, input logic rs,
                      input logic [1:0] es, input logic [3:0] ef);
    logic [6:0] e;
    logic [6:0] o;
    rst        = rs;
    stimulus   = s;
    reanimated = r;
    exp_q.push_back({es, (es == S_EXH), ef});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    o = {state, exhausted, fold_count};
    checks++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed state=%b exh=%b fold=%0d expected state=%b exh=%b fold=%0d",
             tag, o[6:5], o[4], o[3:0], e[6:5], e[4], e[3:0]);
    end
  endtask

  // Three 1-high/2-low pulses from OPEN; third one folds.
  task automatic fold3(input string tag, input logic [3:0] f);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        step(tag, 1'b1, 1'b0, 1'b0, S_CLSD, f + 4'd1);
      end else begin
        step(tag, 1'b1, 1'b0, 1'b0, S_OPEN, f);
        step(tag, 1'b0, 1'b0, 1'b0, S_OPEN, f);
        step(tag, 1'b0, 1'b0, 1'b0, S_OPEN, f);
      end
    end
  endtask

  // From fresh CLOSED entry: 7 idle edges stay, 8th reopens.
  task automatic idle_to_reopen(input string tag, input logic [3:0] f);
    repeat (7) step(tag, 1'b0, 1'b0, 1'b0, S_CLSD, f);
    step(tag, 1'b0, 1'b0, 1'b0, S_REOP, f);
  endtask

  initial begin
    step("reset", 1'b1, 1'b0, 1'b1, S_OPEN, 4'd0);
    step("reset", 1'b1, 1'b0, 1'b1, S_OPEN, 4'd0);
    repeat (3) step("held_level", 1'b1, 1'b0, 1'b0, S_OPEN, 4'd0);
    step("low", 1'b0, 1'b0, 1'b0, S_OPEN, 4'd0);

    fold3("fold", 4'd0);
    idle_to_reopen("recover_closed", 4'd1);
    repeat (7) step("reopening_idle", 1'b0, 1'b0, 1'b0, S_REOP, 4'd1);
    step("reopened", 1'b0, 1'b0, 1'b0, S_OPEN, 4'd1);
    repeat (7) step("open_idle", 1'b0, 1'b0, 1'b0, S_OPEN, 4'd1);
    step("history_clear", 1'b0, 1'b0, 1'b0, S_OPEN, 4'd0);

    fold3("exh_fold1", 4'd0);
    idle_to_reopen("exh_rec1", 4'd1);
    step("exh_fold2", 1'b1, 1'b0, 1'b0, S_CLSD, 4'd2);
    idle_to_reopen("exh_rec2", 4'd2);
    step("exh_fold3", 1'b1, 1'b0, 1'b0, S_CLSD, 4'd3);
    idle_to_reopen("exh_rec3", 4'd3);
    step("exhaust", 1'b1, 1'b0, 1'b0, S_EXH, 4'd4);
    for (int i = 0; i < 8; i++)
      step("exh_ignore", logic'(i % 2), 1'b0, 1'b0, S_EXH, 4'd4);
    step("revive", 1'b0, 1'b1, 1'b0, S_OPEN, 4'd0);
    step("after_revive", 1'b0, 1'b0, 1'b0, S_OPEN, 4'd0);

    step("rean_open_ignored", 1'b0, 1'b1, 1'b0, S_OPEN, 4'd0);
    fold3("fold_again", 4'd0);
    step("rean_closed_ignored", 1'b0, 1'b1, 1'b0, S_CLSD, 4'd1);

    repeat (6) step("closed_to_t7", 1'b0, 1'b0, 1'b0, S_CLSD, 4'd1);
    step("simul_closed", 1'b1, 1'b0, 1'b0, S_CLSD, 4'd1);
    idle_to_reopen("timer_restart", 4'd1);
    repeat (7) step("reop_to_t7", 1'b0, 1'b0, 1'b0, S_REOP, 4'd1);
    step("simul_reopening", 1'b1, 1'b0, 1'b0, S_CLSD, 4'd2);

    idle_to_reopen("to_reopen", 4'd2);
    step("reset_mid", 1'b0, 1'b0, 1'b1, S_OPEN, 4'd0);
    step("after_reset", 1'b0, 1'b0, 1'b0, S_OPEN, 4'd0);
    fold3("fold_after_reset", 4'd0);

    checks++;
    assert (exp_q.size() == 0) else begin
      fails++;
      $error("FAIL queue_drain: observed %0d left expected 0",
             exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
